// File: rtl/mem_pkg.sv
// Shared types and helpers for the register-file memory.
// Holds the clear-engine state encoding and the byte-lane count helper.
package mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int nbytes(input int width);
        return width / BYTE_W;
    endfunction

endpackage

// File: rtl/mem_word.sv
// One WIDTH-bit storage word with per-byte write strobes.
// A synchronous zero has priority over a write so the clear sweep always wins.
module mem_word
    import mem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [nbytes(WIDTH)-1:0]   strb,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       zero,
    output logic [WIDTH-1:0]           q
);

    localparam int NB = nbytes(WIDTH);

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (zero) begin
                    lane_reg <= '0;
                end else if (we && strb[gi]) begin
                    lane_reg <= wdata[gi*8 +: 8];
                end
            end

            assign q[gi*8 +: 8] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/mem_regfile.sv
// Register-file memory: DEPTH x WIDTH words, one write port, one registered read
// port with write-first bypass, and a one-word-per-cycle clear sweep.
module mem_regfile
    import mem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int NB   = nbytes(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [AW-1:0]     waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [NB-1:0]     wstrb,
    input  logic              rd,
    input  logic [AW-1:0]     raddr,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    input  logic              clr,
    output logic              busy,
    output logic              err
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state_reg, state_next;
    logic [AW-1:0]    ptr_reg, ptr_next;
    logic [WIDTH-1:0] rdata_reg;
    logic             rvalid_reg, busy_reg, err_reg, err_next;

    logic             waddr_in, raddr_in, wr_ok, rd_ok;
    logic [WIDTH-1:0] word_q [DEPTH];
    logic [WIDTH-1:0] rword, rmerged;

    assign waddr_in = ({1'b0, waddr} < DEPTH_W);
    assign raddr_in = ({1'b0, raddr} < DEPTH_W);
    assign wr_ok    = (state_reg == ST_IDLE) && wr && waddr_in;
    assign rd_ok    = (state_reg == ST_IDLE) && rd && raddr_in;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            mem_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (wr_ok && (waddr == AW'(gi))),
                .strb  (wstrb),
                .wdata (wdata),
                .zero  ((state_reg == ST_CLEAR) && (ptr_reg == AW'(gi))),
                .q     (word_q[gi])
            );
        end
    endgenerate

    // Read mux followed by write-first merge of any strobed lanes hitting the same word.
    always_comb begin
        rword = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr == AW'(i)) begin
                rword = word_q[i];
            end
        end
        rmerged = rword;
        if (wr_ok && (waddr == raddr)) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    rmerged[b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        err_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wr && !waddr_in) err_next = 1'b1;
                if (rd && !raddr_in) err_next = 1'b1;
                if (clr) begin
                    if (wr || rd) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = ST_CLEAR;
                        ptr_next   = '0;
                    end
                end
            end
            ST_CLEAR: begin
                if (wr || rd) err_next = 1'b1;
                if (ptr_reg == LAST) begin
                    state_next = ST_IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            rdata_reg  <= rd_ok ? rmerged : '0;
            rvalid_reg <= rd_ok;
            busy_reg   <= (state_next == ST_CLEAR);
            err_reg    <= err_next;
        end
    end

    assign rdata  = rdata_reg;
    assign rvalid = rvalid_reg;
    assign busy   = busy_reg;
    assign err    = err_reg;

endmodule
